// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ valid/ready requesters.
// Two-stage pipeline: registered RAM drive, then a registered one-hot response.
module sp_ram_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 8,
   parameter int STRB_WIDTH = 8,
   localparam int _WEN_WIDTH  = WIDTH / STRB_WIDTH,
   localparam int _ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [NUM_REQ-1:0]                REQ_VALID,
   output logic [NUM_REQ-1:0]                REQ_READY,
   input  logic [NUM_REQ*_ADDR_WIDTH-1:0]    REQ_ADDR,
   input  logic [NUM_REQ*WIDTH-1:0]          REQ_D,
   input  logic [NUM_REQ*_WEN_WIDTH-1:0]     REQ_W_EN,
   input  logic [NUM_REQ-1:0]                REQ_LOCK,
   output logic [NUM_REQ-1:0]                RSP_VALID,
   output logic                              RSP_WRITE,
   output logic [WIDTH-1:0]                  RSP_Q,
   output logic [_ADDR_WIDTH-1:0]            RAM_ADDR,
   output logic [WIDTH-1:0]                  RAM_D,
   output logic [_WEN_WIDTH-1:0]             RAM_W_EN,
   input  logic [WIDTH-1:0]                  RAM_Q
);
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int STAGES = 2;

   typedef enum logic {ARB, LOCKED} state_t;

   state_t                                state, state_nxt;
   logic [IDX_W-1:0]                      last, owner, gnt_idx, id1, id2;
   logic                                  found, accept;
   int                                    cand;
   logic [STAGES:1]                       vld_pipe;
   logic [NUM_REQ-1:0][_ADDR_WIDTH-1:0]   addr_a;
   logic [NUM_REQ-1:0][WIDTH-1:0]         d_a;
   logic [NUM_REQ-1:0][_WEN_WIDTH-1:0]    wen_a;

   assign addr_a = REQ_ADDR;
   assign d_a    = REQ_D;
   assign wen_a  = REQ_W_EN;

   // Round-robin search starts just after the last accepted requester.
   always_comb begin
      gnt_idx   = owner;
      found     = 1'b0;
      cand      = 0;
      REQ_READY = '0;
      if (state == ARB) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && REQ_VALID[IDX_W'(cand)]) begin
               found   = 1'b1;
               gnt_idx = IDX_W'(cand);
            end
         end
      end
      if (!RST && (state == LOCKED || found))
         REQ_READY[gnt_idx] = REQ_VALID[gnt_idx];
   end

   assign accept = |REQ_READY;

   always_comb begin
      state_nxt = state;
      if (accept)
         state_nxt = REQ_LOCK[gnt_idx] ? LOCKED : ARB;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ARB;
         last  <= IDX_W'(NUM_REQ - 1);
         owner <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last  <= gnt_idx;
            owner <= gnt_idx;
         end
      end
   end

   // Stage 1 drives the RAM; stage 2 captures its combinational read data.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_pipe  <= '0;
         id1       <= '0;
         id2       <= '0;
         RAM_ADDR  <= '0;
         RAM_D     <= '0;
         RAM_W_EN  <= '0;
         RSP_WRITE <= 1'b0;
         RSP_Q     <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], accept};
         id2      <= id1;
         RAM_W_EN <= '0;
         if (accept) begin
            id1      <= gnt_idx;
            RAM_ADDR <= addr_a[gnt_idx];
            RAM_D    <= d_a[gnt_idx];
            RAM_W_EN <= wen_a[gnt_idx];
         end
         RSP_WRITE <= vld_pipe[1] && (RAM_W_EN != '0);
         RSP_Q     <= (vld_pipe[1] && (RAM_W_EN == '0)) ? RAM_Q : '0;
      end
   end

   always_comb begin
      RSP_VALID = '0;
      if (vld_pipe[STAGES])
         RSP_VALID[id2] = 1'b1;
   end
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural sp_ram model on the RAM port.
module tb_sp_ram_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int D  = 8;
   localparam int S  = 8;
   localparam int WE = W / S;
   localparam int AW = 3;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [N-1:0]      REQ_VALID = '0, REQ_LOCK = '0;
   logic [N-1:0]      REQ_READY, RSP_VALID;
   logic [N*AW-1:0]   REQ_ADDR = '0;
   logic [N*W-1:0]    REQ_D = '0;
   logic [N*WE-1:0]   REQ_W_EN = '0;
   logic              RSP_WRITE;
   logic [W-1:0]      RSP_Q, RAM_D, RAM_Q;
   logic [AW-1:0]     RAM_ADDR;
   logic [WE-1:0]     RAM_W_EN;

   sp_ram_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .STRB_WIDTH(S)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_ADDR(REQ_ADDR), .REQ_D(REQ_D), .REQ_W_EN(REQ_W_EN), .REQ_LOCK(REQ_LOCK),
      .RSP_VALID(RSP_VALID), .RSP_WRITE(RSP_WRITE), .RSP_Q(RSP_Q),
      .RAM_ADDR(RAM_ADDR), .RAM_D(RAM_D), .RAM_W_EN(RAM_W_EN), .RAM_Q(RAM_Q)
   );

   always #5 CLK = ~CLK;

   // sp_ram model: lane writes on the rising edge, combinational read, writes blocked in reset
   logic [W-1:0] mem [D];
   logic         pre = 1'b1;

   function automatic logic [W-1:0] init_word(int i);
      case (i)
         2:       return 16'h1234;
         3:       return 16'h00A5;
         default: return 16'(i * 16'h1111);
      endcase
   endfunction

   always @(posedge CLK) begin
      if (pre) begin
         for (int i = 0; i < D; i++) mem[i] <= init_word(i);
      end else if (!RST) begin
         for (int l = 0; l < WE; l++)
            if (RAM_W_EN[l]) mem[RAM_ADDR][l*S +: S] <= RAM_D[l*S +: S];
      end
   end
   assign RAM_Q = mem[RAM_ADDR];

   typedef struct {
      logic [N-1:0]  v, lk;
      int            r;
      logic [AW-1:0] a;
      logic [W-1:0]  d;
      logic [WE-1:0] w;
      logic [N-1:0]  rdy, rv;
      logic          rw;
      logic [W-1:0]  rq;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0, errors = 0, row = -1;

   task automatic add(input logic [N-1:0] v, lk, input int r, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic [WE-1:0] w,
                      input logic [N-1:0] rdy, rv, input logic rw, input logic [W-1:0] rq);
      vec_t t;
      t.v = v; t.lk = lk; t.r = r; t.a = a; t.d = d; t.w = w;
      t.rdy = rdy; t.rv = rv; t.rw = rw; t.rq = rq;
      tbl.push_back(t);
   endtask

   // Focus requester r carries the row payload; the others read address i.
   task automatic drive(input vec_t t);
      for (int i = 0; i < N; i++) begin
         REQ_ADDR[i*AW +: AW] = (i == t.r) ? t.a : AW'(i);
         REQ_D[i*W +: W]      = (i == t.r) ? t.d : '0;
         REQ_W_EN[i*WE +: WE] = (i == t.r) ? t.w : '0;
      end
      REQ_VALID = t.v;
      REQ_LOCK  = t.lk;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
      end
   endtask

   initial begin
      // contention from reset: order 0,1,2,3,0,1
      add(4'b1111, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0);
      add(4'b1111, 0, 0, 0, 0, 0, 4'b0010, 4'b0000, 0, 0);
      add(4'b1111, 0, 0, 0, 0, 0, 4'b0100, 4'b0001, 0, 16'h0000);
      add(4'b1111, 0, 0, 0, 0, 0, 4'b1000, 4'b0010, 0, 16'h1111);
      add(4'b1111, 0, 0, 0, 0, 0, 4'b0001, 4'b0100, 0, 16'h1234);
      add(4'b1111, 0, 0, 0, 0, 0, 4'b0010, 4'b1000, 0, 16'h00A5);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 16'h0000);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 0, 16'h1111);
      // single read req1 addr 3
      add(4'b0010, 0, 1, 3, 0, 0, 4'b0010, 4'b0000, 0, 0);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 0, 16'h00A5);
      // partial write upper lane of addr 2, then read back
      add(4'b0001, 0, 0, 2, 16'hABCD, 2'b10, 4'b0001, 4'b0000, 0, 0);
      add(4'b0001, 0, 0, 2, 0, 0, 4'b0001, 4'b0000, 0, 0);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 1, 16'h0000);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 16'hAB34);
      // locked read-modify-write by req2 with a bubble, req0/req3 waiting
      add(4'b1101, 4'b0100, 2, 5, 0, 0, 4'b0100, 4'b0000, 0, 0);
      add(4'b1001, 4'b0000, 2, 5, 0, 0, 4'b0000, 4'b0000, 0, 0);
      add(4'b1101, 4'b0000, 2, 5, 16'hBEEF, 2'b11, 4'b0100, 4'b0100, 0, 16'h5555);
      add(4'b1001, 0, 2, 5, 0, 0, 4'b1000, 4'b0000, 0, 0);
      add(4'b1001, 0, 2, 5, 0, 0, 4'b0001, 4'b0100, 1, 16'h0000);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 16'h00A5);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 16'h0000);
      // read-after-write back-to-back, then confirm the locked write landed
      add(4'b0010, 0, 1, 6, 16'h003C, 2'b11, 4'b0010, 4'b0000, 0, 0);
      add(4'b0100, 0, 2, 6, 0, 0, 4'b0100, 4'b0000, 0, 0);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 1, 16'h0000);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 0, 16'h003C);
      add(4'b1000, 0, 3, 5, 0, 0, 4'b1000, 4'b0000, 0, 0);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
      add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 16'hBEEF);

      // reset state, with requests pending
      REQ_VALID = 4'b1111;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", REQ_READY, 0);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_rsp_write", RSP_WRITE, 0);
      chk("rst_rsp_q", RSP_Q, 0);
      chk("rst_ram_addr", RAM_ADDR, 0);
      chk("rst_ram_d", RAM_D, 0);
      chk("rst_ram_wen", RAM_W_EN, 0);
      pre = 1'b0;
      REQ_VALID = '0;
      RST = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         row = i;
         @(negedge CLK);
         drive(tbl[i]);
         #1;
         chk("ready", REQ_READY, tbl[i].rdy);
         chk("rsp_valid", RSP_VALID, tbl[i].rv);
         if (tbl[i].rv != '0) begin
            chk("rsp_write", RSP_WRITE, tbl[i].rw);
            chk("rsp_q", RSP_Q, tbl[i].rq);
         end
      end

      // reset while a write by req1 to addr 4 is in flight
      row = 100;
      @(negedge CLK);
      REQ_VALID = 4'b0010; REQ_LOCK = '0;
      REQ_ADDR[1*AW +: AW] = 3'd4;
      REQ_D[1*W +: W]      = 16'h0077;
      REQ_W_EN[1*WE +: WE] = 2'b11;
      #1;
      chk("mid_accept", REQ_READY, 4'b0010);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      REQ_VALID = '0;
      #1;
      chk("mid_ram_wen", RAM_W_EN, 0);
      chk("mid_ram_addr", RAM_ADDR, 0);
      chk("mid_ram_d", RAM_D, 0);
      chk("mid_rsp_write", RSP_WRITE, 0);
      chk("mid_rsp_q", RSP_Q, 0);
      for (int k = 0; k < 3; k++) begin
         row = 101 + k;
         @(negedge CLK);
         chk("mid_no_rsp", RSP_VALID, 0);
      end
      chk("mid_mem4", mem[4], 16'h4444);
      row = 110;
      REQ_VALID = 4'b1111;
      RST = 1'b0;
      #1;
      chk("post_rst_grant", REQ_READY, 4'b0001);
      @(negedge CLK);
      REQ_VALID = '0;
      #1;
      chk("post_rst_no_rsp", RSP_VALID, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
